// File: rtl/sha256_pkg.sv
// SHA-256 constants, round helper functions and shared types for the
// iterative compression core.
package sha256_pkg;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } sha256_state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_FINAL
  } sha256_fsm_t;

  localparam sha256_state_t IV = '{
    a: 32'h6a09e667, b: 32'hbb67ae85, c: 32'h3c6ef372, d: 32'ha54ff53a,
    e: 32'h510e527f, f: 32'h9b05688c, g: 32'h1f83d9ab, h: 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic sha256_state_t add_state(input sha256_state_t x, input sha256_state_t y);
    sha256_state_t r;
    r.a = x.a + y.a;
    r.b = x.b + y.b;
    r.c = x.c + y.c;
    r.d = x.d + y.d;
    r.e = x.e + y.e;
    r.f = x.f + y.f;
    r.g = x.g + y.g;
    r.h = x.h + y.h;
    return r;
  endfunction

endpackage

// File: rtl/sha256_round_step.sv
// One combinational SHA-256 round: state, K_t and W_t in, next state out.
module sha256_round_step
  import sha256_pkg::*;
(
  input  sha256_state_t state_i,
  input  logic [31:0]   k_i,
  input  logic [31:0]   w_i,
  output sha256_state_t state_o
);

  logic [31:0] t1;
  logic [31:0] t2;

  always_comb begin
    t1 = state_i.h + big_sigma1(state_i.e) + ch(state_i.e, state_i.f, state_i.g) + k_i + w_i;
    t2 = big_sigma0(state_i.a) + maj(state_i.a, state_i.b, state_i.c);
    state_o.a = t1 + t2;
    state_o.b = state_i.a;
    state_o.c = state_i.b;
    state_o.d = state_i.c;
    state_o.e = state_i.d + t1;
    state_o.f = state_i.e;
    state_o.g = state_i.f;
    state_o.h = state_i.g;
  end

endmodule

// File: rtl/sha256_compress_core.sv
// Iterative SHA-256 compression: UNROLL rounds per clock over a 16-word
// sliding schedule window, folding the result into the H chaining registers.
module sha256_compress_core
  import sha256_pkg::*;
#(
  parameter int unsigned UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         init,
  input  logic [511:0] block_in,
  output logic         busy,
  output logic         done,
  output logic [255:0] digest
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
    $error("sha256_compress_core: UNROLL must be 1, 2, 4 or 8");
  end

  localparam logic [5:0] J_STEP = 6'(UNROLL);
  localparam logic [5:0] J_LAST = 6'(64 - UNROLL);

  sha256_fsm_t          state_q, state_d;
  logic [5:0]           j_q, j_d;
  logic [15:0][31:0]    w_q, w_d;
  sha256_state_t        vars_q, vars_d;
  sha256_state_t        h_q, h_d;
  logic                 done_q, done_d;

  logic [31:0]          ext [16+UNROLL];
  sha256_state_t        rounds_out;

  // ext[0..15] is the live window; later words are expanded in order so that
  // words produced earlier in the same cycle feed the ones after them.
  always_comb begin
    for (int unsigned k = 0; k < 16; k++) ext[k] = w_q[k];
    for (int unsigned i = 0; i < UNROLL; i++) begin
      ext[16+i] = small_sigma1(ext[14+i]) + ext[9+i] + small_sigma0(ext[1+i]) + ext[i];
    end
  end

  for (genvar gi = 0; gi < UNROLL; gi++) begin : g_round
    sha256_state_t st_in;
    sha256_state_t st_out;
    logic [5:0]    k_idx;

    if (gi == 0) begin : g_first
      assign st_in = vars_q;
    end else begin : g_next
      assign st_in = g_round[gi-1].st_out;
    end

    assign k_idx = j_q + 6'(gi);

    sha256_round_step u_step (
      .state_i (st_in),
      .k_i     (K[k_idx]),
      .w_i     (ext[gi]),
      .state_o (st_out)
    );
  end

  assign rounds_out = g_round[UNROLL-1].st_out;

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    w_d     = w_q;
    vars_d  = vars_q;
    h_d     = h_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ROUND;
          j_d     = '0;
          for (int unsigned k = 0; k < 16; k++) w_d[k] = block_in[511 - 32*k -: 32];
          vars_d  = init ? IV : h_q;
          if (init) h_d = IV;
        end
      end
      ST_ROUND: begin
        vars_d = rounds_out;
        for (int unsigned k = 0; k < 16; k++) w_d[k] = ext[k+UNROLL];
        j_d = j_q + J_STEP;
        if (j_q == J_LAST) state_d = ST_FINAL;
      end
      ST_FINAL: begin
        h_d     = add_state(h_q, vars_q);
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      j_q     <= '0;
      w_q     <= '0;
      vars_q  <= '0;
      h_q     <= IV;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      w_q     <= w_d;
      vars_q  <= vars_d;
      h_q     <= h_d;
      done_q  <= done_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign digest = h_q;

endmodule

// File: tb/tb_sha256_compress_core.sv
// Scoreboard bench: known-answer SHA-256 blocks on UNROLL = 1, 2, 4, 8 instances.
module tb_sha256_compress_core;

  localparam logic [255:0] IV_DIG    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_MID   = 256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;
  localparam logic [255:0] TWO_DIG   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};

  typedef struct {
    int           dut;
    logic [255:0] dig;
    int           lat;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         init;
  logic [511:0] block;
  logic         start_v  [4];
  logic         busy_v   [4];
  logic         done_v   [4];
  logic [255:0] digest_v [4];

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sha256_compress_core #(.UNROLL(1 << g)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start_v[g]),
      .init     (init),
      .block_in (block),
      .busy     (busy_v[g]),
      .done     (done_v[g]),
      .digest   (digest_v[g])
    );
  end

  function automatic void chk(input string name, input int d,
                              input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (dut %0d): got %h required %h", name, d, act, exp);
    end
  endfunction

  // Caller is positioned at a negedge with the target instance idle.
  task automatic issue(input int d, input logic ini, input logic [511:0] blk,
                       input bit push, input logic [255:0] dig);
    exp_t e;
    start_v[d] = 1'b1;
    init       = ini;
    block      = blk;
    if (push) begin
      e.dut = d;
      e.dig = dig;
      e.lat = (64 >> d) + 1;
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    start_v[d] = 1'b0;
    init       = ~ini;
    block      = '1;
  endtask

  task automatic pulse_ignored(input int d, input logic [511:0] blk);
    start_v[d] = 1'b1;
    init       = 1'b1;
    block      = blk;
    @(negedge clk);
    start_v[d] = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int i = 0;
    while (sb.size() != 0 && i < budget) begin
      @(posedge clk);
      i++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d commands pending after %0d cycles, required 0", sb.size(), budget);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_done(input int d, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = (done_v[d] === 1'b1);
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL done_timeout (dut %0d): no done within %0d cycles", d, budget);
    end
  endtask

  initial begin
    rst   = 1'b1;
    init  = 1'b0;
    block = '0;
    for (int d = 0; d < 4; d++) start_v[d] = 1'b0;
    fork
      begin : monitor
        exp_t it;
        forever begin
          @(negedge clk);
          for (int d = 0; d < 4; d++) begin
            if (done_v[d] === 1'b1) begin
              if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL spurious_done (dut %0d): done pulsed with no command pending", d);
              end else begin
                it = sb.pop_front();
                chk("done_dut", d, 256'(d), 256'(it.dut));
                chk("digest", d, digest_v[d], it.dig);
                chk("latency", d, 256'(cyc - it.acc), 256'(it.lat));
                chk("busy_at_done", d, 256'(busy_v[d]), 256'(0));
              end
            end
          end
        end
      end
      begin : stimulus
        repeat (3) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
          chk("reset_busy", d, 256'(busy_v[d]), 256'(0));
          chk("reset_done", d, 256'(done_v[d]), 256'(0));
          chk("reset_digest", d, digest_v[d], IV_DIG);
        end
        rst = 1'b0;
        @(negedge clk);

        // "abc" with two ignored starts mid-run
        issue(0, 1'b1, BLK_ABC, 1'b1, ABC_DIG);
        repeat (3) @(negedge clk);
        pulse_ignored(0, BLK_EMPTY);
        repeat (24) @(negedge clk);
        pulse_ignored(0, BLK_EMPTY);
        wait_drain(200);
        repeat (10) @(negedge clk);

        // Empty message on every unroll factor
        for (int d = 0; d < 4; d++) begin
          issue(d, 1'b1, BLK_EMPTY, 1'b1, EMPTY_DIG);
          wait_drain(200);
        end

        // Two-block message, second block issued in the done cycle
        issue(0, 1'b1, BLK_TWO1, 1'b1, TWO_MID);
        wait_done(0, 100);
        issue(0, 1'b0, BLK_TWO2, 1'b1, TWO_DIG);
        wait_drain(200);

        // Reset mid-operation, with start held high during reset
        issue(0, 1'b1, BLK_ABC, 1'b1, ABC_DIG);
        wait_drain(200);
        issue(0, 1'b0, BLK_ABC, 1'b0, '0);
        repeat (20) @(negedge clk);
        rst        = 1'b1;
        start_v[0] = 1'b1;
        #1;
        chk("abort_busy", 0, 256'(busy_v[0]), 256'(0));
        chk("abort_digest", 0, digest_v[0], IV_DIG);
        repeat (3) @(negedge clk);
        chk("rst_held_done", 0, 256'(done_v[0]), 256'(0));
        start_v[0] = 1'b0;
        rst        = 1'b0;
        #1;
        chk("post_rst_busy", 0, 256'(busy_v[0]), 256'(0));
        chk("post_rst_digest", 0, digest_v[0], IV_DIG);
        @(negedge clk);
        repeat (80) @(negedge clk);
        issue(0, 1'b1, BLK_ABC, 1'b1, ABC_DIG);
        wait_drain(200);
        repeat (5) @(negedge clk);

        chk("queue_empty", 0, 256'(sb.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
    join
  end

endmodule
